// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic units.
// Pure declarations: no timing and no flow control of its own.
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Borrow out of one full-subtractor stage computing ai - bi - bin.
  function automatic logic fs_bout(input logic ai, input logic bi, input logic bin);
    return (~ai & bi) | (~(ai ^ bi) & bin);
  endfunction

endpackage

// File: rtl/fs_cell.sv
// Combinational full subtractor: d = ai - bi - bin, with borrow out.
// Zero latency; no handshake, outputs follow inputs.
module fs_cell
  import serial_arith_pkg::*;
(
  input  logic ai,
  input  logic bi,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = ai ^ bi ^ bin;
  assign bout = fs_bout(ai, bi, bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock; done pulses WIDTH cycles after start is taken.
// start is only sampled in IDLE/DONE; while busy it is ignored, not queued.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             borrow;
  logic [CW-1:0]    count;
  logic             d;
  logic             bout;

  fs_cell u_cell (
    .ai   (shift_a[0]),
    .bi   (shift_b[0]),
    .bin  (borrow),
    .d    (d),
    .bout (bout)
  );

  // New bit enters at the MSB so after WIDTH shifts bit 0 lands at position 0.
  assign res_next = {d, res[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      shift_a    <= '0;
      shift_b    <= '0;
      res        <= '0;
      borrow     <= 1'b0;
      count      <= '0;
    end else begin
      case (state)
        RUN: begin
          shift_a <= shift_a >> 1;
          shift_b <= shift_b >> 1;
          res     <= res_next;
          borrow  <= bout;
          if (count == LAST) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            diff       <= res_next;
            borrow_out <= bout;
            count      <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            shift_a <= a;
            shift_b <= b;
            res     <= '0;
            borrow  <= 1'b0;
            count   <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH=8: scoreboard of expected results checked on each done pulse.
module tb_serial_subtractor;
  import serial_arith_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [W-1:0] prev_diff;
  logic         prev_bo;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t r;
    r.diff   = x - y;
    r.borrow = (x < y);
    return r;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding operation,
  // and the result outputs must not move on any other cycle.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (done) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got diff=%h borrow=%b with nothing outstanding", diff, borrow_out);
        end else begin
          mon_e = exp_q.pop_front();
          if ({diff, borrow_out} !== {mon_e.diff, mon_e.borrow}) begin
            errors++;
            $display("FAIL result: got diff=%h borrow=%b, want diff=%h borrow=%b",
                     diff, borrow_out, mon_e.diff, mon_e.borrow);
          end
        end
      end else if (diff !== prev_diff || borrow_out !== prev_bo) begin
        errors++;
        $display("FAIL hold: result moved without done, %h/%b -> %h/%b", prev_diff, prev_bo, diff, borrow_out);
      end
    end
    prev_diff = diff;
    prev_bo   = borrow_out;
  end

  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clk);
    #1;
    a = x; b = y; start = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(x, y));
    #1;
    start = 1'b0;
    a = ~x; b = ~y;
  endtask

  // Returns the number of edges from acceptance to done, or -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #3;
    start = 1'b1; a = 8'h5A; b = 8'h23;
    @(negedge clk);
    checks++;
    if ({busy, done, diff, borrow_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%h borrow=%b, want all 0", busy, done, diff, borrow_out);
    end
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d, want IDLE", dut.state);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || dut.state !== IDLE) begin
        errors++;
        $display("FAIL idle_after_reset: got busy=%b done=%b state=%0d, want 0/0/IDLE", busy, done, dut.state);
      end
    end
  endtask

  task automatic test_basic();
    int lat;
    int busy_cnt;
    lat = -1;
    busy_cnt = 0;
    start_op(8'h5A, 8'h23);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != W) begin
      errors++;
      $display("FAIL basic_latency: got %0d, want %0d", lat, W);
    end
    checks++;
    if (busy_cnt != W) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d, want %0d", busy_cnt, W);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_in_done: got %b, want 0", busy);
    end
  endtask

  task automatic test_operands(input string name, input logic [W-1:0] x, input logic [W-1:0] y);
    int lat;
    start_op(x, y);
    wait_done(lat);
    checks++;
    if (lat != W) begin
      errors++;
      $display("FAIL %s_latency: got %0d, want %0d", name, lat, W);
    end
  endtask

  task automatic test_back_to_back();
    int  lat;
    time t_prev;
    t_prev = 0;
    @(posedge clk);
    #1;
    a = 8'h9C; b = 8'hC9; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      exp_q.push_back(model(a, b));
      #1;
      a = 8'($urandom);
      b = 8'($urandom);
      wait_done(lat);
      checks++;
      if (lat != W) begin
        errors++;
        $display("FAIL b2b_latency: op %0d got %0d, want %0d", i, lat, W);
      end
      if (i > 0) begin
        checks++;
        if ($time - t_prev != 10 * (W + 1)) begin
          errors++;
          $display("FAIL b2b_interval: got %0t, want %0d", $time - t_prev, 10 * (W + 1));
        end
      end
      t_prev = $time;
    end
    start = 1'b0;
  endtask

  task automatic test_start_in_run();
    int lat;
    start_op(8'h10, 8'h01);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; a = 8'hFF; b = 8'h00;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL midrun_latency: got %0d, want 4", lat);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL midrun_not_queued: got busy=%b, want 0", busy);
      end
    end
  endtask

  task automatic test_abort();
    int lat;
    int dones;
    start_op(8'h5A, 8'h23);
    wait_done(lat);
    start_op(8'hC3, 8'h11);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, diff, borrow_out} !== '0 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL abort_clear: got busy=%b done=%b diff=%h borrow=%b state=%0d, want all 0/IDLE",
               busy, done, diff, borrow_out, dut.state);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d pulses, want 0", dones);
    end
    start_op(8'h77, 8'h78);
    wait_done(lat);
    checks++;
    if (lat != W) begin
      errors++;
      $display("FAIL abort_restart_latency: got %0d, want %0d", lat, W);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_operands("underflow_a", 8'h03, 8'h05);
    test_operands("underflow_b", 8'h00, 8'hFF);
    test_operands("equal_ff", 8'hFF, 8'hFF);
    test_operands("borrow_chain", 8'h80, 8'h01);
    test_back_to_back();
    test_start_in_run();
    test_abort();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL outstanding: got %0d results never produced, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, want completion before 200000");
    $fatal(1);
  end

endmodule
